// File: rtl/gerencia_turno_pkg.sv
// Shared game constants for the turn manager and the board FSM:
// state encodings, turn-count saturation value and counter helpers.
package gerencia_turno_pkg;

    typedef enum logic [1:0] {
        INICIAL = 2'b00,
        ESPERA  = 2'b01,
        TROCA   = 2'b10,
        FIM     = 2'b11
    } estado_t;

    localparam int MAX_JOGADAS_PADRAO = 9;
    localparam int NUM_JOGADAS_W      = 4;

    // Increment that sticks at the limit instead of wrapping.
    function automatic logic [NUM_JOGADAS_W-1:0] incr_sat(
        input logic [NUM_JOGADAS_W-1:0] valor,
        input logic [NUM_JOGADAS_W-1:0] limite
    );
        return (valor >= limite) ? valor : valor + 1'b1;
    endfunction

endpackage

// File: rtl/gerencia_turno_if.sv
// Handshake bundle between the board logic (master) and the turn manager (slave).
interface gerencia_turno_if;
    import gerencia_turno_pkg::*;

    logic                     iniciar;
    logic                     jogada;
    logic                     jogada_valida;
    logic                     fim_jogo;
    logic                     jogador;
    logic                     vez_ativa;
    logic                     timeout;
    logic [NUM_JOGADAS_W-1:0] num_jogadas;
    logic [1:0]               db_estado;

    modport master (
        output iniciar, jogada, jogada_valida, fim_jogo,
        input  jogador, vez_ativa, timeout, num_jogadas, db_estado
    );

    modport slave (
        input  iniciar, jogada, jogada_valida, fim_jogo,
        output jogador, vez_ativa, timeout, num_jogadas, db_estado
    );

endinterface

// File: rtl/gerencia_turno_contador_m.sv
// Modulo-N counter with synchronous clear and enable; o_fim flags the
// terminal value MODULO-1, after which the count wraps to zero.
module contador_m #(
    parameter int MODULO = 8,
    parameter int W      = (MODULO > 1) ? $clog2(MODULO) : 1
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_fim
);

    logic [W-1:0] r_valor;
    logic         w_fim;

    assign w_fim = (r_valor == W'(MODULO - 1));
    assign o_fim = w_fim;

    always_ff @(posedge clock) begin
        if (reset || i_clr) begin
            r_valor <= '0;
        end else if (i_en) begin
            r_valor <= w_fim ? '0 : r_valor + 1'b1;
        end
    end

endmodule

// File: rtl/gerencia_turno.sv
// Turn manager: alternates players, forces a pass when the turn timer
// expires, counts completed turns and freezes on end of game.
module gerencia_turno
    import gerencia_turno_pkg::*;
#(
    parameter int LIMITE_TEMPO = 5000,
    parameter int MAX_JOGADAS  = MAX_JOGADAS_PADRAO
) (
    input  logic              clock,
    input  logic              reset,
    gerencia_turno_if.slave   bus
);

    localparam int TW = (LIMITE_TEMPO > 1) ? $clog2(LIMITE_TEMPO) : 1;
    localparam logic [NUM_JOGADAS_W-1:0] LIM_N = NUM_JOGADAS_W'(MAX_JOGADAS);

    estado_t                  r_estado;
    estado_t                  w_estado_next;
    logic                     r_jogador;
    logic                     w_jogador_next;
    logic [NUM_JOGADAS_W-1:0] r_num;
    logic [NUM_JOGADAS_W-1:0] w_num_next;
    logic                     w_timeout;
    logic                     w_expira;
    logic                     w_tmr_clr;
    logic                     w_tmr_en;

    // The timer only runs while waiting for a move and is zero everywhere else.
    assign w_tmr_en  = (r_estado == ESPERA);
    assign w_tmr_clr = (w_estado_next != ESPERA);

    contador_m #(
        .MODULO (LIMITE_TEMPO),
        .W      (TW)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .i_clr  (w_tmr_clr),
        .i_en   (w_tmr_en),
        .o_fim  (w_expira)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado  <= INICIAL;
            r_jogador <= 1'b0;
            r_num     <= '0;
        end else begin
            r_estado  <= w_estado_next;
            r_jogador <= w_jogador_next;
            r_num     <= w_num_next;
        end
    end

    always_comb begin
        w_estado_next  = r_estado;
        w_jogador_next = r_jogador;
        w_num_next     = r_num;
        w_timeout      = 1'b0;
        unique case (r_estado)
            INICIAL: begin
                w_jogador_next = 1'b0;
                w_num_next     = '0;
                if (bus.iniciar) begin
                    w_estado_next = ESPERA;
                end
            end
            ESPERA: begin
                // End of game outranks a move, which outranks expiry.
                if (bus.fim_jogo) begin
                    w_estado_next = FIM;
                end else if (bus.jogada && bus.jogada_valida) begin
                    w_estado_next = TROCA;
                end else if (w_expira) begin
                    w_timeout     = 1'b1;
                    w_estado_next = TROCA;
                end
            end
            TROCA: begin
                if (bus.fim_jogo) begin
                    w_estado_next = FIM;
                end else begin
                    w_jogador_next = ~r_jogador;
                    w_num_next     = incr_sat(r_num, LIM_N);
                    w_estado_next  = ESPERA;
                end
            end
            FIM: begin
                if (bus.iniciar) begin
                    w_estado_next  = INICIAL;
                    w_jogador_next = 1'b0;
                    w_num_next     = '0;
                end
            end
            default: begin
                w_estado_next = INICIAL;
            end
        endcase
    end

    assign bus.jogador     = r_jogador;
    assign bus.vez_ativa   = (r_estado == ESPERA);
    assign bus.timeout     = w_timeout;
    assign bus.num_jogadas = r_num;
    assign bus.db_estado   = r_estado;

endmodule

// File: tb/tb_gerencia_turno.sv
// Directed bench for gerencia_turno with an 8-cycle turn limit; expected
// outputs go through a scoreboard queue and are checked mid-cycle.
module tb_gerencia_turno;

    logic clock = 1'b0;
    logic reset = 1'b1;

    gerencia_turno_if bus ();

    gerencia_turno #(
        .LIMITE_TEMPO (8),
        .MAX_JOGADAS  (9)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      tag;
        logic [1:0] est;
        logic       jog;
        logic       vez;
        logic       to;
        logic [3:0] num;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Drive one cycle of inputs at the falling edge, queue what the outputs
    // must show in that cycle, then pop and compare a moment later.
    task automatic step(input logic rs, input logic ini, input logic jg,
                        input logic jv, input logic fm, input string tag,
                        input logic [1:0] e_est, input logic e_jog,
                        input logic e_vez, input logic e_to,
                        input logic [3:0] e_num);
        exp_t e;
        exp_t o;
        @(negedge clock);
        reset             = rs;
        bus.iniciar       = ini;
        bus.jogada        = jg;
        bus.jogada_valida = jv;
        bus.fim_jogo      = fm;
        e.tag = tag;
        e.est = e_est;
        e.jog = e_jog;
        e.vez = e_vez;
        e.to  = e_to;
        e.num = e_num;
        sb.push_back(e);
        #1;
        o = sb.pop_front();
        n_tests++;
        assert (bus.db_estado === o.est) else begin
            n_fail++;
            $error("FAIL %s db_estado got %0d expected %0d", o.tag, bus.db_estado, o.est);
        end
        n_tests++;
        assert (bus.jogador === o.jog) else begin
            n_fail++;
            $error("FAIL %s jogador got %0b expected %0b", o.tag, bus.jogador, o.jog);
        end
        n_tests++;
        assert (bus.vez_ativa === o.vez) else begin
            n_fail++;
            $error("FAIL %s vez_ativa got %0b expected %0b", o.tag, bus.vez_ativa, o.vez);
        end
        n_tests++;
        assert (bus.timeout === o.to) else begin
            n_fail++;
            $error("FAIL %s timeout got %0b expected %0b", o.tag, bus.timeout, o.to);
        end
        n_tests++;
        assert (bus.num_jogadas === o.num) else begin
            n_fail++;
            $error("FAIL %s num_jogadas got %0d expected %0d", o.tag, bus.num_jogadas, o.num);
        end
        $display("[TB] %s est=%0d jog=%0b vez=%0b to=%0b num=%0d", o.tag,
                 bus.db_estado, bus.jogador, bus.vez_ativa, bus.timeout, bus.num_jogadas);
    endtask

    initial begin
        bus.iniciar       = 1'b0;
        bus.jogada        = 1'b0;
        bus.jogada_valida = 1'b0;
        bus.fim_jogo      = 1'b0;

        // Reset, start, first valid move and its two-edge toggle latency.
        step(1, 0, 0, 0, 0, "reset",       2'd0, 0, 0, 0, 4'd0);
        step(0, 1, 0, 0, 0, "inicial",     2'd0, 0, 0, 0, 4'd0);
        step(0, 0, 1, 1, 0, "espera_move", 2'd1, 0, 1, 0, 4'd0);
        step(0, 0, 0, 0, 0, "troca",       2'd2, 0, 0, 0, 4'd0);

        // Two full timeout periods of 9 cycles; an invalid move in the first.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 7; i++) begin
                step(0, 0, (k == 0 && i == 1), 0, 0, "espera_wait",
                     2'd1, (k == 0), 1, 0, 4'(1 + k));
            end
            step(0, 0, 0, 0, 0, "timeout",    2'd1, (k == 0), 1, 1, 4'(1 + k));
            step(0, 0, 0, 0, 0, "troca_to",   2'd2, (k == 0), 0, 0, 4'(1 + k));
        end

        // Valid move on the expiry cycle: move wins, no timeout pulse.
        for (int i = 0; i < 7; i++) begin
            step(0, 0, 0, 0, 0, "espera_pre_exp", 2'd1, 1, 1, 0, 4'd3);
        end
        step(0, 0, 1, 1, 0, "move_at_expiry", 2'd1, 1, 1, 0, 4'd3);
        step(0, 0, 0, 0, 0, "troca_exp",      2'd2, 1, 0, 0, 4'd3);

        // Seven more valid moves; iniciar in ESPERA/TROCA must be ignored.
        for (int m = 0; m < 7; m++) begin
            step(0, (m == 0), 1, 1, 0, "esp_move",   2'd1, 1'(m % 2), 1, 0,
                 4'((4 + m > 9) ? 9 : 4 + m));
            step(0, (m == 0), 0, 0, 0, "troca_move", 2'd2, 1'(m % 2), 0, 0,
                 4'((4 + m > 9) ? 9 : 4 + m));
        end
        step(0, 0, 0, 0, 0, "saturado",        2'd1, 1, 1, 0, 4'd9);

        // fim_jogo during TROCA: no toggle, frozen in FIM until iniciar.
        step(0, 0, 1, 1, 0, "move_before_fim", 2'd1, 1, 1, 0, 4'd9);
        step(0, 0, 0, 0, 1, "fim_in_troca",    2'd2, 1, 0, 0, 4'd9);
        step(0, 0, 0, 0, 0, "fim_hold",        2'd3, 1, 0, 0, 4'd9);
        step(0, 1, 0, 0, 0, "fim_iniciar",     2'd3, 1, 0, 0, 4'd9);
        step(0, 1, 0, 0, 0, "reiniciado",      2'd0, 0, 0, 0, 4'd0);

        // fim_jogo together with a valid move on the expiry cycle.
        for (int i = 0; i < 7; i++) begin
            step(0, 0, 0, 0, 0, "espera2",     2'd1, 0, 1, 0, 4'd0);
        end
        step(0, 0, 1, 1, 1, "fim_at_expiry",   2'd1, 0, 1, 0, 4'd0);
        step(0, 0, 0, 0, 0, "fim_no_toggle",   2'd3, 0, 0, 0, 4'd0);
        step(0, 1, 0, 0, 0, "fim_ini2",        2'd3, 0, 0, 0, 4'd0);
        step(0, 1, 0, 0, 0, "ini2",            2'd0, 0, 0, 0, 4'd0);

        // Reset mid-ESPERA, reset over iniciar, reset during TROCA.
        step(0, 0, 0, 0, 0, "esp3",            2'd1, 0, 1, 0, 4'd0);
        step(0, 0, 0, 0, 0, "esp3",            2'd1, 0, 1, 0, 4'd0);
        step(1, 0, 0, 0, 0, "esp_rst_drive",   2'd1, 0, 1, 0, 4'd0);
        step(0, 0, 0, 0, 0, "rst_mid_espera",  2'd0, 0, 0, 0, 4'd0);
        step(1, 1, 0, 0, 0, "rst_ini",         2'd0, 0, 0, 0, 4'd0);
        step(0, 0, 0, 0, 0, "rst_prio",        2'd0, 0, 0, 0, 4'd0);
        step(0, 1, 0, 0, 0, "ini3",            2'd0, 0, 0, 0, 4'd0);
        step(0, 0, 1, 1, 0, "esp4",            2'd1, 0, 1, 0, 4'd0);
        step(1, 0, 0, 0, 0, "troca_rst_drive", 2'd2, 0, 0, 0, 4'd0);
        step(0, 0, 0, 0, 0, "rst_troca",       2'd0, 0, 0, 0, 4'd0);

        // Fresh game: timer starts from zero, full period to timeout.
        step(0, 1, 0, 0, 0, "ini4",            2'd0, 0, 0, 0, 4'd0);
        for (int i = 0; i < 7; i++) begin
            step(0, 0, 0, 0, 0, "espera5",     2'd1, 0, 1, 0, 4'd0);
        end
        step(0, 0, 0, 0, 0, "timeout5",        2'd1, 0, 1, 1, 4'd0);
        step(0, 0, 0, 0, 0, "troca5",          2'd2, 0, 0, 0, 4'd0);
        step(0, 0, 0, 0, 0, "apos_troca5",     2'd1, 1, 1, 0, 4'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gerencia_turno.md
GERENCIA_TURNO -- requirements
Module: gerencia_turno

Interface
REQ-001 Parameter LIMITE_TEMPO, default 5000: clock cycles allowed per turn before a forced pass.
REQ-002 Parameter MAX_JOGADAS, default 9: turn-count saturation value.
REQ-003 clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 iniciar  input  1  start/restart game; level sampled each cycle.
REQ-006 jogada  input  1  one-cycle pulse: current player submitted a move.
REQ-007 jogada_valida  input  1  board logic accepts the move; qualified by jogada in the same cycle.
REQ-008 fim_jogo  input  1  board logic reports win or draw.
REQ-009 jogador  output  1  current player: 0 = player 1, 1 = player 2; drives the player display decoder.
REQ-010 vez_ativa  output  1  high while a move is awaited (state ESPERA).
REQ-011 timeout  output  1  one-cycle pulse when a turn expires.
REQ-012 num_jogadas  output  4  completed turns this game, valid moves plus timeouts.
REQ-013 db_estado  output  2  current state encoding, for debug.

Function
REQ-014 FSM states SHALL be INICIAL=00, ESPERA=01, TROCA=10, FIM=11, registered, Moore outputs except timeout.
REQ-015 INICIAL: jogador=0, turn timer=0, num_jogadas=0; iniciar=1 -> ESPERA next cycle.
REQ-016 ESPERA: turn timer increments by 1 every cycle; vez_ativa=1.
REQ-017 ESPERA with jogada=1 and jogada_valida=1 -> TROCA.
REQ-018 ESPERA with jogada=1 and jogada_valida=0: ignored; timer keeps counting; no state change.
REQ-019 ESPERA with timer == LIMITE_TEMPO-1 and no valid move: timeout=1 for that cycle only; -> TROCA.
REQ-020 Valid move and expiry in the same cycle: the move wins; timeout stays 0.
REQ-021 TROCA (one cycle): jogador toggles, timer clears to 0, num_jogadas increments saturating at MAX_JOGADAS; -> ESPERA.
REQ-022 fim_jogo=1 in ESPERA or TROCA: -> FIM next cycle, highest priority; no toggle, no count increment, no timeout pulse that cycle.
REQ-023 FIM: jogador, num_jogadas frozen (jogador identifies last mover); timer held at 0; vez_ativa=0.
REQ-024 FIM with iniciar=1: -> INICIAL next cycle (clears jogador/counters); iniciar held high then advances to ESPERA.
REQ-025 iniciar while in ESPERA or TROCA SHALL be ignored.
REQ-026 Timer width SHALL be ceil(log2(LIMITE_TEMPO)) bits; never exceeds LIMITE_TEMPO-1.
REQ-027 Move-to-toggle latency: jogador changes exactly 2 clock edges after the cycle jogada/jogada_valida are sampled high.

Reset
REQ-028 reset=1 at a clock edge SHALL force INICIAL, jogador=0, vez_ativa=0, timeout=0, num_jogadas=0, timer=0, db_estado=00, regardless of state, including mid-turn and during TROCA.
REQ-029 reset SHALL take priority over every other input.

Structure
REQ-030 State encodings and MAX_JOGADAS SHALL live in the shared game constants include (jogo_velha_defs), reused by the board FSM.
REQ-031 Turn timer SHALL be a sub-module contador_m (parameterized modulo counter: clear, enable, terminal-count output); the FSM is in gerencia_turno.

Verification
REQ-032 reset, iniciar pulse, then valid jogada -> jogador 0->1 two edges later; num_jogadas=1; vez_ativa drops for one cycle.
REQ-033 LIMITE_TEMPO=8, no moves -> timeout pulse on 8th ESPERA cycle, jogador toggles, repeats every 9 cycles.
REQ-034 jogada=1, jogada_valida=0 -> jogador unchanged, timer not reset, timeout still fires at limit.
REQ-035 LIMITE_TEMPO=8, valid move on the expiry cycle -> toggle, timeout=0; and fim_jogo in TROCA -> FIM, jogador not toggled.
REQ-036 10 valid moves -> num_jogadas saturates at 9; fim_jogo then iniciar -> INICIAL, all zero; reset asserted mid-ESPERA -> INICIAL next edge.
